// File: rtl/mm_cmd_issuer.sv
// -----------------------------------------------------------------------------
// mm_cmd_issuer
//
// Host-side initiator for the matrix-multiply controller. Host commands
// (dimensions plus A/B/P base addresses) are queued in a small FIFO. The
// commands are then issued one at a time over a four-phase start/valid
// handshake:
//   IDLE -> (pop) -> REQ  : start_o high until valid_i is sampled high
//   REQ  -> ACK           : start_o low, wait for valid_i to drop
//   ACK  -> RSP           : response presented until rsp_ready_i
//   RSP  -> IDLE
// The response carries the number of cycles start_o was high.
//
// Optional feature macro: MM_CMD_ZERO_CHECK_EN
//   When defined, a popped command with m, k or n equal to zero is not
//   issued. It is answered straight from IDLE with rsp_err_o=1 and
//   rsp_cycles_o=0. When undefined, every command is issued and rsp_err_o
//   is tied low.
//
// Address width comes from the ADDR_WIDTH macro (normally defined in def.v).
// The local fallback below only applies when no definition is present.
//
// Parameters:
//   FIFO_DEPTH  command FIFO entries (power of two, >= 2)
//   CNT_WIDTH   width of the saturating busy-cycle counter
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o        host command handshake (ready = not full)
//   cmd_{m,k,n}_i                    command dimensions
//   cmd_base_{a,b,p}_i               command base addresses
//   start_o / valid_i                controller handshake
//   m_o, k_o, n_o, base_addr{a,b,p}_o  command presented to the controller
//   rsp_valid_o / rsp_ready_i        response handshake
//   rsp_cycles_o                     cycles start_o was high for this command
//   rsp_err_o                        command rejected (zero-dimension check)
//   busy_o                           FSM not idle or FIFO non-empty
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module mm_cmd_issuer #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [`ADDR_WIDTH-1:0] cmd_m_i,
  input  logic [`ADDR_WIDTH-1:0] cmd_k_i,
  input  logic [`ADDR_WIDTH-1:0] cmd_n_i,
  input  logic [`ADDR_WIDTH-1:0] cmd_base_a_i,
  input  logic [`ADDR_WIDTH-1:0] cmd_base_b_i,
  input  logic [`ADDR_WIDTH-1:0] cmd_base_p_i,
  output logic                   start_o,
  input  logic                   valid_i,
  output logic [`ADDR_WIDTH-1:0] m_o,
  output logic [`ADDR_WIDTH-1:0] k_o,
  output logic [`ADDR_WIDTH-1:0] n_o,
  output logic [`ADDR_WIDTH-1:0] base_addra_o,
  output logic [`ADDR_WIDTH-1:0] base_addrb_o,
  output logic [`ADDR_WIDTH-1:0] base_addrp_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [CNT_WIDTH-1:0]   rsp_cycles_o,
  output logic                   rsp_err_o,
  output logic                   busy_o
);

  localparam int AW    = `ADDR_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]     CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]     OCC_ZERO = (PTR_W + 1)'(0);
  localparam logic [PTR_W:0]     DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] BUSY_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] BUSY_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] BUSY_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [AW-1:0]      ADDR_ZERO = AW'(0);

  typedef struct packed {
    logic [AW-1:0] m;
    logic [AW-1:0] k;
    logic [AW-1:0] n;
    logic [AW-1:0] base_a;
    logic [AW-1:0] base_b;
    logic [AW-1:0] base_p;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2,
    ST_RSP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             ready_q;

  cmd_t             cmd_in_s;
  cmd_t             head_s;
  logic             push_s;
  logic             pop_s;
  logic             empty_s;

  // ---------------------------------------------------------------------------
  // Issue FSM and registered outputs
  // ---------------------------------------------------------------------------
  state_t                state_q;
  logic                  start_q;
  logic                  rsp_valid_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [AW-1:0]         m_q;
  logic [AW-1:0]         k_q;
  logic [AW-1:0]         n_q;
  logic [AW-1:0]         base_a_q;
  logic [AW-1:0]         base_b_q;
  logic [AW-1:0]         base_p_q;

`ifdef MM_CMD_ZERO_CHECK_EN
  logic                  rsp_err_q;
  logic                  zero_dim_s;
`endif

  assign cmd_in_s = '{m:      cmd_m_i,
                      k:      cmd_k_i,
                      n:      cmd_n_i,
                      base_a: cmd_base_a_i,
                      base_b: cmd_base_b_i,
                      base_p: cmd_base_p_i};

  assign head_s  = mem_q[rd_ptr_q];
  assign empty_s = (count_q == OCC_ZERO);

  // Push uses the registered ready, so a push never lands on a full FIFO.
  assign push_s = cmd_valid_i && ready_q;
  // The FSM consumes the head only from IDLE; no bypass from the input.
  assign pop_s  = (state_q == ST_IDLE) && !empty_s;

`ifdef MM_CMD_ZERO_CHECK_EN
  assign zero_dim_s = (head_s.m == ADDR_ZERO) ||
                      (head_s.k == ADDR_ZERO) ||
                      (head_s.n == ADDR_ZERO);
`endif

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= cmd_in_s;
    end
  end

  // FIFO pointers, occupancy and registered ready (held low during reset).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= OCC_ZERO;
      ready_q  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
      ready_q <= (count_d != DEPTH_C);
    end
  end

  // Handshake FSM with all controller/response outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q       <= BUSY_ZERO;
      m_q         <= ADDR_ZERO;
      k_q         <= ADDR_ZERO;
      n_q         <= ADDR_ZERO;
      base_a_q    <= ADDR_ZERO;
      base_b_q    <= ADDR_ZERO;
      base_p_q    <= ADDR_ZERO;
`ifdef MM_CMD_ZERO_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            // The command registers load on every pop, rejected or not.
            m_q      <= head_s.m;
            k_q      <= head_s.k;
            n_q      <= head_s.n;
            base_a_q <= head_s.base_a;
            base_b_q <= head_s.base_b;
            base_p_q <= head_s.base_p;
            cnt_q    <= BUSY_ZERO;
`ifdef MM_CMD_ZERO_CHECK_EN
            if (zero_dim_s) begin
              state_q     <= ST_RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= ST_REQ;
              start_q     <= 1'b1;
              rsp_err_q   <= 1'b0;
            end
`else
            state_q <= ST_REQ;
            start_q <= 1'b1;
`endif
          end
        end

        ST_REQ: begin
          // Every REQ cycle counts, including the one that samples valid_i.
          if (cnt_q != BUSY_MAX) begin
            cnt_q <= cnt_q + BUSY_ONE;
          end
          if (valid_i) begin
            state_q <= ST_ACK;
            start_q <= 1'b0;
          end
        end

        ST_ACK: begin
          if (!valid_i) begin
            state_q     <= ST_RSP;
            rsp_valid_q <= 1'b1;
          end
        end

        ST_RSP: begin
          // valid_i is ignored here; only the host accept moves us on.
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          start_q     <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o  = ready_q;
  assign start_o      = start_q;
  assign m_o          = m_q;
  assign k_o          = k_q;
  assign n_o          = n_q;
  assign base_addra_o = base_a_q;
  assign base_addrb_o = base_b_q;
  assign base_addrp_o = base_p_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_cycles_o = cnt_q;
  // Pure OR of state and occupancy flops; both are zero out of reset.
  assign busy_o       = (state_q != ST_IDLE) || !empty_s;

`ifdef MM_CMD_ZERO_CHECK_EN
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule
